// File: rtl/seq_event_logger.sv
// seq_event_logger: timestamps rising edges of a detector output and queues them in a FIFO.
// Ports: clk, rst (async, active-high), clr (sync clear), det (detector output),
//        rd_en (pop request), rd_valid/rd_data (registered pop result),
//        empty/full/level (FIFO occupancy), overflow (sticky drop flag),
//        event_count/drop_count (saturating counters).
// Optional: define SEQ_EVENT_LOGGER_GAP_MEAS_EN to add min_gap/gap_valid
//        (smallest interval between consecutive events).
module seq_event_logger #(
    parameter int TS_W  = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     det,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [TS_W-1:0]          rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         event_count,
`ifdef SEQ_EVENT_LOGGER_GAP_MEAS_EN
    output logic [CNT_W-1:0]         drop_count,
    output logic [TS_W-1:0]          min_gap,
    output logic                     gap_valid
`else
    output logic [CNT_W-1:0]         drop_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem [DEPTH];
    logic [AW:0]     wp, rp;
    logic            det_q, ev, rd_ok, wr_ok, drop;
    assign ev    = det & ~det_q;
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = ev & (~full | rd_ok);
    assign drop  = ev & full & ~rd_ok;
    // Pointer MSBs differ only when the FIFO has wrapped a full lap.
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign level = wp - rp;
    always_ff @(posedge clk or posedge rst)
        if (rst) ts <= '0;
        else     ts <= ts + TS_W'(1);
    always_ff @(posedge clk)
        if (wr_ok) mem[wp[AW-1:0]] <= ts;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            det_q       <= 1'b0;
            wp          <= '0;
            rp          <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            overflow    <= 1'b0;
            event_count <= '0;
            drop_count  <= '0;
        end else if (clr) begin
            det_q       <= 1'b0;
            wp          <= '0;
            rp          <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            overflow    <= 1'b0;
            event_count <= '0;
            drop_count  <= '0;
        end else begin
            det_q    <= det;
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_data <= mem[rp[AW-1:0]];
                rp      <= rp + (AW+1)'(1);
            end
            if (wr_ok) wp <= wp + (AW+1)'(1);
            if (ev && ~&event_count) event_count <= event_count + CNT_W'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (~&drop_count) drop_count <= drop_count + CNT_W'(1);
            end
        end
`ifdef SEQ_EVENT_LOGGER_GAP_MEAS_EN
    logic [TS_W-1:0] ts_prev, gap;
    logic            have_prev;
    assign gap = ts - ts_prev;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ts_prev   <= '0;
            have_prev <= 1'b0;
            min_gap   <= '1;
            gap_valid <= 1'b0;
        end else if (clr) begin
            ts_prev   <= '0;
            have_prev <= 1'b0;
            min_gap   <= '1;
            gap_valid <= 1'b0;
        end else if (ev) begin
            ts_prev   <= ts;
            have_prev <= 1'b1;
            if (have_prev) begin
                gap_valid <= 1'b1;
                if (gap < min_gap) min_gap <= gap;
            end
        end
`endif
endmodule

// File: tb/tb_seq_event_logger.sv
// tb_seq_event_logger: directed and randomized checks of seq_event_logger against a queue model.
module tb_seq_event_logger;
    logic       clk = 1'b0, rst = 1'b1, clr = 1'b0, det = 1'b0, rd_en = 1'b0;
    logic       rd_valid, empty, full, overflow;
    logic [7:0] rd_data, event_count, drop_count;
    logic [2:0] level;
`ifdef SEQ_EVENT_LOGGER_GAP_MEAS_EN
    logic [7:0] min_gap;
    logic       gap_valid;
`endif
    seq_event_logger dut (
        .clk(clk), .rst(rst), .clr(clr), .det(det), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_data(rd_data), .empty(empty), .full(full),
        .level(level), .overflow(overflow), .event_count(event_count),
`ifdef SEQ_EVENT_LOGGER_GAP_MEAS_EN
        .drop_count(drop_count), .min_gap(min_gap), .gap_valid(gap_valid)
`else
        .drop_count(drop_count)
`endif
    );
    always #5 clk = ~clk;
    int total = 0, passed = 0;
    int mts, mrd, mev, mdrop, mgap, mprev;
    bit mdetq, mrv, mov, mgv;
    int q[$];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask
    task automatic model_clear();
        q.delete();
        mdetq = 0; mrv = 0; mrd = 0; mov = 0; mev = 0; mdrop = 0;
        mgap = 255; mgv = 0; mprev = -1;
    endtask
    task automatic model_reset();
        model_clear();
        mts = 0;
    endtask
    task automatic check_all();
        chk("rd_valid", rd_valid, mrv);
        chk("rd_data", rd_data, mrd);
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == 4);
        chk("level", level, q.size());
        chk("overflow", overflow, mov);
        chk("event_count", event_count, mev);
        chk("drop_count", drop_count, mdrop);
`ifdef SEQ_EVENT_LOGGER_GAP_MEAS_EN
        chk("min_gap", min_gap, mgap);
        chk("gap_valid", gap_valid, mgv);
`endif
    endtask
    task automatic step();
        bit ev, pop, was_full;
        int g;
        @(posedge clk);
        #1;
        if (clr) model_clear();
        else begin
            ev = det && !mdetq;
            was_full = q.size() == 4;
            pop = rd_en && q.size() > 0;
            mrv = pop;
            if (pop) mrd = q.pop_front();
            if (ev) begin
                if (mev < 255) mev++;
                if (!was_full || pop) q.push_back(mts);
                else begin
                    mov = 1;
                    if (mdrop < 255) mdrop++;
                end
                if (mprev >= 0) begin
                    g = (mts - mprev) & 255;
                    if (g < mgap) mgap = g;
                    mgv = 1;
                end
                mprev = mts;
            end
            mdetq = det;
        end
        mts = (mts + 1) & 255;
        check_all();
    endtask
    task automatic wait_ts(input int n);
        while (mts != n) step();
    endtask
    task automatic pulse_at(input int n);
        wait_ts(n);
        det = 1;
        step();
        det = 0;
    endtask
    initial begin
        int drain4[4] = '{14, 16, 18, 20};
        int ovf[5] = '{2, 4, 6, 8, 10};
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 0;
        pulse_at(5);
        rd_en = 1;
        step();
        rd_en = 0;
        chk("basic_rd_valid", rd_valid, 1);
        chk("basic_rd_data", rd_data, 5);
        chk("basic_event_count", event_count, 1);
        step();
        chk("basic_empty", empty, 1);
        chk("basic_pulse_end", rd_valid, 0);
        wait_ts(10);
        det = 1;
        repeat (3) step();
        det = 0;
        step();
        chk("hold_level", level, 1);
        chk("hold_event_count", event_count, 2);
        rd_en = 1;
        step();
        rd_en = 0;
        chk("hold_rd_data", rd_data, 10);
        for (int t = 12; t <= 18; t += 2) pulse_at(t);
        chk("fill_full", full, 1);
        wait_ts(20);
        det = 1;
        rd_en = 1;
        step();
        det = 0;
        chk("simul_rd_data", rd_data, 12);
        chk("simul_level", level, 4);
        chk("simul_drop", drop_count, 0);
        foreach (drain4[i]) begin
            step();
            chk("simul_drain", rd_data, drain4[i]);
        end
        rd_en = 0;
        pulse_at(255);
        pulse_at(1);
        rd_en = 1;
        step();
        chk("wrap_first", rd_data, 255);
        step();
        chk("wrap_second", rd_data, 1);
        step();
        rd_en = 0;
        chk("empty_read_valid", rd_valid, 0);
        chk("empty_read_data", rd_data, 1);
`ifdef SEQ_EVENT_LOGGER_GAP_MEAS_EN
        chk("wrap_min_gap", min_gap, 2);
        chk("wrap_gap_valid", gap_valid, 1);
`endif
        clr = 1;
        step();
        clr = 0;
        chk("clr_event_count", event_count, 0);
        foreach (ovf[i]) pulse_at(ovf[i]);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_count, 1);
        chk("ovf_events", event_count, 5);
        rd_en = 1;
        step();
        rd_en = 0;
        chk("ovf_first", rd_data, 2);
        chk("ovf_level", level, 3);
        #2 rst = 1;
        #1;
        model_reset();
        check_all();
        #1 rst = 0;
        det = 1;
        step();
        det = 0;
        rd_en = 1;
        step();
        rd_en = 0;
        chk("post_rst_ts", rd_data, 0);
        for (int p = 0; p < 4; p++)
            repeat (800) begin
                det = 1'($urandom_range(0, 1));
                rd_en = $urandom_range(0, 7) < 2 * p;
                clr = $urandom_range(0, 499) == 0;
                step();
            end
        clr = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
